// File: rtl/uart_bus_master.sv
// uart_bus_master: pulls framed commands byte-by-byte from a UART receive
// path, runs one 32-bit access on a simple memory bus, and returns the
// result bytes through the UART transmit path.
//
// Handshake semantics (all three interfaces):
//   - uart_read, uart_write, bus_read and bus_write are single-cycle
//     request pulses and are registered outputs.
//   - A UART response counts only on its rising level in the matching wait
//     state. The master then waits for the response to drop before it
//     issues the next request, so a response held high for several cycles
//     is consumed exactly once.
//   - bus_ack is sampled only in BUS_WAIT. An ack arriving in any other
//     state has no effect.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx_empty,
  output logic        uart_read,
  input  logic        uart_read_response,
  input  logic [31:0] uart_read_data,
  output logic        uart_write,
  input  logic        uart_write_response,
  output logic [31:0] uart_write_data,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DONE  = 3'd2,
    BUS_REQ  = 3'd3,
    BUS_WAIT = 3'd4,
    TX_REQ   = 3'd5,
    TX_WAIT  = 3'd6,
    TX_DONE  = 3'd7
  } state_t;

  state_t           state;
  logic [3:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       cmd_reg;
  logic [7:0]       rx_byte;
  logic [31:0]      addr_reg;
  logic [31:0]      data_reg;
  logic [31:0]      tx_shift;
  logic [2:0]       tx_cnt;
  logic             frame_last;

  // The byte being dispatched is the final byte of the current frame.
  assign frame_last = (cmd_reg == CMD_READ) ? (byte_cnt == 4'd4) : (byte_cnt == 4'd8);

  // Busy covers both an active transaction and a half-received frame.
  assign busy      = (state != IDLE) || (byte_cnt != 4'd0);
  assign state_dbg = state;

  // Main control FSM: request pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      byte_cnt        <= 4'd0;
      tmo_cnt         <= '0;
      cmd_reg         <= 8'h00;
      rx_byte         <= 8'h00;
      addr_reg        <= 32'h0;
      data_reg        <= 32'h0;
      tx_shift        <= 32'h0;
      tx_cnt          <= 3'd0;
      uart_read       <= 1'b0;
      uart_write      <= 1'b0;
      uart_write_data <= 32'h0;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      bus_address     <= 32'h0;
      bus_write_data  <= 32'h0;
    end else begin
      uart_read  <= 1'b0;
      uart_write <= 1'b0;
      bus_read   <= 1'b0;
      bus_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (!uart_rx_empty) begin
            uart_read <= 1'b1;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (uart_read_response) begin
            rx_byte <= uart_read_data[7:0];
            state   <= RD_DONE;
          end
        end
        RD_DONE: begin
          if (!uart_read_response) begin
            if (byte_cnt == 4'd0) begin
              // Unknown command bytes are dropped while waiting for a frame start.
              if ((rx_byte == CMD_READ) || (rx_byte == CMD_WRITE)) begin
                cmd_reg  <= rx_byte;
                byte_cnt <= 4'd1;
              end
              state <= IDLE;
            end else begin
              if (byte_cnt <= 4'd4) begin
                addr_reg <= {addr_reg[23:0], rx_byte};
              end else begin
                data_reg <= {data_reg[23:0], rx_byte};
              end
              if (frame_last) begin
                byte_cnt <= 4'd0;
                state    <= BUS_REQ;
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
                state    <= IDLE;
              end
            end
          end
        end
        BUS_REQ: begin
          bus_address    <= addr_reg;
          bus_write_data <= data_reg;
          bus_read       <= (cmd_reg == CMD_READ);
          bus_write      <= (cmd_reg != CMD_READ);
          tmo_cnt        <= '0;
          state          <= BUS_WAIT;
        end
        BUS_WAIT: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (bus_ack) begin
            if (cmd_reg == CMD_READ) begin
              tx_shift <= bus_read_data;
              tx_cnt   <= 3'd4;
            end else begin
              tx_shift <= {ACK_BYTE, 24'h0};
              tx_cnt   <= 3'd1;
            end
            state <= TX_REQ;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt  <= tmo_cnt + TMO_W'(1);
            tx_shift <= {NAK_BYTE, 24'h0};
            tx_cnt   <= 3'd1;
            state    <= TX_REQ;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        TX_REQ: begin
          uart_write_data <= {tx_shift[31:24], 24'h0};
          tx_shift        <= {tx_shift[23:0], 8'h00};
          tx_cnt          <= tx_cnt - 3'd1;
          uart_write      <= 1'b1;
          state           <= TX_WAIT;
        end
        TX_WAIT: begin
          if (uart_write_response) begin
            state <= TX_DONE;
          end
        end
        TX_DONE: begin
          if (!uart_write_response) begin
            state <= (tx_cnt != 3'd0) ? TX_REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed tests for uart_bus_master with a cycle-level
// UART/bus responder model and per-scenario inline checks.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx_empty = 1'b1;
  logic        uart_read;
  logic        uart_read_response = 1'b0;
  logic [31:0] uart_read_data = 32'h0;
  logic        uart_write;
  logic        uart_write_response = 1'b0;
  logic [31:0] uart_write_data;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = 32'h0;
  logic        bus_ack = 1'b0;
  logic        busy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int passed = 0;

  // Responder model state
  logic [7:0]  rx_q[$];
  logic [31:0] tx_got[$];
  logic [7:0]  m_byte;
  logic [31:0] bus_rdata = 32'h0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  int rsp_len = 1;
  int ack_delay = -1;
  int ack_timer = -1;
  int force_ack = 0;
  int rd_hold = 0;
  int wr_hold = 0;
  int n_uart_read = 0;
  int n_bus_read = 0;
  int n_bus_write = 0;
  int n_overlap = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int first_wr_cyc = 0;

  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .uart_rx_empty       (uart_rx_empty),
    .uart_read           (uart_read),
    .uart_read_response  (uart_read_response),
    .uart_read_data      (uart_read_data),
    .uart_write          (uart_write),
    .uart_write_response (uart_write_response),
    .uart_write_data     (uart_write_data),
    .bus_read            (bus_read),
    .bus_write           (bus_write),
    .bus_address         (bus_address),
    .bus_write_data      (bus_write_data),
    .bus_read_data       (bus_read_data),
    .bus_ack             (bus_ack),
    .busy                (busy),
    .state_dbg           (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // UART peripheral and memory bus responder, updated 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!resetn) begin
      rd_hold = 0;
      wr_hold = 0;
      ack_timer = -1;
      uart_read_response = 1'b0;
      uart_write_response = 1'b0;
      bus_ack = 1'b0;
      bus_read_data = 32'h0;
    end else begin
      if (uart_read && uart_write) n_overlap++;
      if (uart_read) begin
        n_uart_read++;
        if (rx_q.size() > 0) begin
          m_byte = rx_q.pop_front();
          uart_read_data = {24'h0, m_byte};
        end
        rd_hold = rsp_len;
      end
      if (rd_hold > 0) begin
        uart_read_response = 1'b1;
        rd_hold--;
      end else begin
        uart_read_response = 1'b0;
      end
      if (uart_write) begin
        tx_got.push_back(uart_write_data);
        if (tx_got.size() == 1) first_wr_cyc = cyc;
        wr_hold = rsp_len;
      end
      if (wr_hold > 0) begin
        uart_write_response = 1'b1;
        wr_hold--;
      end else begin
        uart_write_response = 1'b0;
      end
      if (bus_read || bus_write) begin
        if (bus_read) n_bus_read++;
        if (bus_write) n_bus_write++;
        last_addr = bus_address;
        last_wdata = bus_write_data;
        strobe_cyc = cyc;
        ack_timer = ack_delay;
      end
      if (force_ack > 0) begin
        bus_ack = 1'b1;
        force_ack--;
      end else if (ack_timer == 0) begin
        bus_ack = 1'b1;
        ack_timer = -1;
      end else begin
        bus_ack = 1'b0;
        if (ack_timer > 0) ack_timer--;
      end
      bus_read_data = bus_ack ? bus_rdata : 32'h0;
    end
    uart_rx_empty = (rx_q.size() == 0);
  end

  // Driver tasks
  task automatic clear_model();
    n_uart_read = 0;
    n_bus_read = 0;
    n_bus_write = 0;
    tx_got.delete();
  endtask

  task automatic push_frame(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) rx_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && !busy && !uart_read && !uart_read_response && !uart_write_response) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else passed++;
    checks++; if ({uart_read, uart_write, bus_read, bus_write, busy} !== 5'b0) $display("FAIL reset_strobes: got %b want 00000", {uart_read, uart_write, bus_read, bus_write, busy}); else passed++;
    checks++; if ({uart_write_data, bus_address, bus_write_data} !== 96'h0) $display("FAIL reset_data: got %h want 0", {uart_write_data, bus_address, bus_write_data}); else passed++;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (uart_read !== 1'b0) $display("FAIL reset_idle_no_read: got %b want 0", uart_read); else passed++;
  endtask

  task automatic test_write();
    bit ok;
    clear_model();
    rsp_len = 1; ack_delay = 2;
    push_frame(72'h57_00_00_10_00_DE_AD_BE_EF, 9);
    wait_done(400, ok);
    checks++; if (!ok) $display("FAIL wr_done: got timeout want completion"); else passed++;
    checks++; if (n_uart_read !== 9) $display("FAIL wr_reads: got %0d want 9", n_uart_read); else passed++;
    checks++; if (n_bus_write !== 1 || n_bus_read !== 0) $display("FAIL wr_strobes: got w=%0d r=%0d want w=1 r=0", n_bus_write, n_bus_read); else passed++;
    checks++; if (last_addr !== 32'h0000_1000) $display("FAIL wr_addr: got %h want 00001000", last_addr); else passed++;
    checks++; if (last_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_data: got %h want deadbeef", last_wdata); else passed++;
    checks++; if (tx_got.size() !== 1) $display("FAIL wr_tx_count: got %0d want 1", tx_got.size()); else passed++;
    checks++; if (tx_got[0] !== 32'h0600_0000) $display("FAIL wr_tx_ack: got %h want 06000000", tx_got[0]); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL wr_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_read();
    bit ok;
    logic [31:0] exp_rd [4];
    exp_rd = '{32'h1200_0000, 32'h3400_0000, 32'h5600_0000, 32'h7800_0000};
    clear_model();
    rsp_len = 1; ack_delay = 1; bus_rdata = 32'h1234_5678;
    push_frame({32'h0, 40'h52_00_00_00_04}, 5);
    wait_done(400, ok);
    checks++; if (!ok) $display("FAIL rd_done: got timeout want completion"); else passed++;
    checks++; if (n_bus_read !== 1 || n_bus_write !== 0) $display("FAIL rd_strobes: got r=%0d w=%0d want r=1 w=0", n_bus_read, n_bus_write); else passed++;
    checks++; if (last_addr !== 32'h0000_0004) $display("FAIL rd_addr: got %h want 00000004", last_addr); else passed++;
    checks++; if (tx_got.size() !== 4) $display("FAIL rd_tx_count: got %0d want 4", tx_got.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_got[i] !== exp_rd[i]) $display("FAIL rd_tx_byte%0d: got %h want %h", i, tx_got[i], exp_rd[i]); else passed++;
    end
  endtask

  task automatic test_invalid_cmd();
    bit ok;
    clear_model();
    rsp_len = 1; ack_delay = 0; bus_rdata = 32'hA1B2_C3D4;
    push_frame({64'h0, 8'h41}, 1);
    wait_done(100, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok || n_uart_read !== 1) $display("FAIL inv_consumed: got ok=%0d reads=%0d want ok=1 reads=1", ok, n_uart_read); else passed++;
    checks++; if (n_bus_read + n_bus_write !== 0) $display("FAIL inv_no_bus: got %0d want 0", n_bus_read + n_bus_write); else passed++;
    checks++; if (tx_got.size() !== 0) $display("FAIL inv_no_tx: got %0d want 0", tx_got.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL inv_busy: got %b want 0", busy); else passed++;
    push_frame({32'h0, 40'h52_00_00_00_08}, 5);
    wait_done(400, ok);
    checks++; if (!ok || n_bus_read !== 1) $display("FAIL inv_then_rd: got ok=%0d r=%0d want ok=1 r=1", ok, n_bus_read); else passed++;
    checks++; if (last_addr !== 32'h0000_0008) $display("FAIL inv_rd_addr: got %h want 00000008", last_addr); else passed++;
    checks++; if (tx_got.size() !== 4) $display("FAIL inv_rd_tx_count: got %0d want 4", tx_got.size()); else passed++;
    checks++; if (tx_got[0] !== 32'hA100_0000 || tx_got[3] !== 32'hD400_0000) $display("FAIL inv_rd_tx: got %h/%h want a1000000/d4000000", tx_got[0], tx_got[3]); else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    clear_model();
    rsp_len = 1; ack_delay = -1;
    push_frame({32'h0, 40'h52_00_00_00_0C}, 5);
    wait_done(400, ok);
    checks++; if (!ok) $display("FAIL tmo_done: got timeout want completion"); else passed++;
    checks++; if (tx_got.size() !== 1) $display("FAIL tmo_tx_count: got %0d want 1", tx_got.size()); else passed++;
    checks++; if (tx_got[0] !== 32'h1500_0000) $display("FAIL tmo_nak: got %h want 15000000", tx_got[0]); else passed++;
    // 16 BUS_WAIT cycles, one TX_REQ cycle, then the write pulse.
    checks++; if (first_wr_cyc - strobe_cyc !== 17) $display("FAIL tmo_latency: got %0d want 17", first_wr_cyc - strobe_cyc); else passed++;
    force_ack = 1;
    repeat (6) @(negedge clk);
    checks++; if (tx_got.size() !== 1 || state_dbg !== 3'd0) $display("FAIL tmo_late_ack: got tx=%0d state=%0d want tx=1 state=0", tx_got.size(), state_dbg); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_model();
    rsp_len = 1; ack_delay = 2;
    push_frame({48'h0, 24'h57_00_00}, 3);
    repeat (30) @(negedge clk);
    checks++; if (busy !== 1'b1 || n_uart_read !== 3) $display("FAIL mid_partial_busy: got busy=%b reads=%0d want busy=1 reads=3", busy, n_uart_read); else passed++;
    resetn = 1'b0;
    @(negedge clk);
    checks++; if ({uart_read, uart_write, bus_read, bus_write, busy} !== 5'b0) $display("FAIL mid_reset_strobes: got %b want 00000", {uart_read, uart_write, bus_read, bus_write, busy}); else passed++;
    checks++; if ({uart_write_data, bus_address, bus_write_data} !== 96'h0) $display("FAIL mid_reset_data: got %h want 0", {uart_write_data, bus_address, bus_write_data}); else passed++;
    resetn = 1'b1;
    clear_model();
    push_frame(72'h57_00_00_00_20_CA_FE_F0_0D, 9);
    wait_done(400, ok);
    checks++; if (!ok || n_bus_write !== 1) $display("FAIL mid_wr: got ok=%0d w=%0d want ok=1 w=1", ok, n_bus_write); else passed++;
    checks++; if (last_addr !== 32'h0000_0020) $display("FAIL mid_wr_addr: got %h want 00000020", last_addr); else passed++;
    checks++; if (last_wdata !== 32'hCAFE_F00D) $display("FAIL mid_wr_data: got %h want cafef00d", last_wdata); else passed++;
    checks++; if (tx_got.size() !== 1 || tx_got[0] !== 32'h0600_0000) $display("FAIL mid_wr_ack: got n=%0d %h want n=1 06000000", tx_got.size(), tx_got[0]); else passed++;
  endtask

  task automatic test_stretched();
    bit ok;
    clear_model();
    // Ack lands in the 16th BUS_WAIT cycle, the same cycle the timeout limit is hit.
    rsp_len = 2; ack_delay = 15;
    push_frame(72'h57_00_00_00_40_11_22_33_44, 9);
    wait_done(600, ok);
    checks++; if (!ok || n_uart_read !== 9) $display("FAIL str_wr_reads: got ok=%0d reads=%0d want ok=1 reads=9", ok, n_uart_read); else passed++;
    checks++; if (n_bus_write !== 1 || last_addr !== 32'h0000_0040) $display("FAIL str_wr_bus: got w=%0d addr=%h want w=1 addr=00000040", n_bus_write, last_addr); else passed++;
    checks++; if (last_wdata !== 32'h1122_3344) $display("FAIL str_wr_data: got %h want 11223344", last_wdata); else passed++;
    checks++; if (tx_got.size() !== 1 || tx_got[0] !== 32'h0600_0000) $display("FAIL str_wr_ack: got n=%0d %h want n=1 06000000", tx_got.size(), tx_got[0]); else passed++;
    clear_model();
    rsp_len = 3; ack_delay = 15; bus_rdata = 32'h9ABC_DEF0;
    push_frame({32'h0, 40'h52_00_00_00_44}, 5);
    wait_done(600, ok);
    checks++; if (!ok || n_uart_read !== 5 || n_bus_read !== 1) $display("FAIL str_rd: got ok=%0d reads=%0d r=%0d want 1/5/1", ok, n_uart_read, n_bus_read); else passed++;
    checks++; if (last_addr !== 32'h0000_0044) $display("FAIL str_rd_addr: got %h want 00000044", last_addr); else passed++;
    checks++; if (tx_got.size() !== 4) $display("FAIL str_rd_tx_count: got %0d want 4", tx_got.size()); else passed++;
    checks++; if ({tx_got[0][31:24], tx_got[1][31:24], tx_got[2][31:24], tx_got[3][31:24]} !== 32'h9ABC_DEF0) $display("FAIL str_rd_tx: got %h%h%h%h want 9abcdef0", tx_got[0][31:24], tx_got[1][31:24], tx_got[2][31:24], tx_got[3][31:24]); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_invalid_cmd();
    test_timeout();
    test_reset_mid_frame();
    test_stretched();
    checks++; if (n_overlap !== 0) $display("FAIL rw_overlap: got %0d want 0", n_overlap); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
Host-side command master for the UART peripheral's read/write/response request interface. It pulls bytes one at a time from the UART receive path and assembles framed commands. It executes each command as a single 32-bit access on a simple memory bus, then pushes the result bytes back out through the UART transmit path. It sits between the byte-wide UART peripheral (configured for one byte per access) and the controller's internal bus.

Parameters:
TIMEOUT_CYCLES, 1000, maximum number of BUS_WAIT cycles before a bus access is declared failed (minimum 1).
CMD_READ, 8'h52, command byte for a read frame.
CMD_WRITE, 8'h57, command byte for a write frame.
ACK_BYTE, 8'h06, byte returned after a successful write.
NAK_BYTE, 8'h15, byte returned after a bus timeout.

Ports:
clk  in  1  system clock; all logic is on the rising edge
resetn  in  1  synchronous, active-low reset
uart_rx_empty  in  1  UART receive FIFO is empty
uart_read  out  1  one-cycle read request to the UART peripheral
uart_read_response  in  1  read complete; may stay high for more than one cycle
uart_read_data  in  32  received byte in bits [7:0]
uart_write  out  1  one-cycle write request to the UART peripheral
uart_write_response  in  1  write accepted; may stay high for more than one cycle
uart_write_data  out  32  byte to send in bits [31:24]; bits [23:0] are zero
bus_read  out  1  one-cycle bus read strobe
bus_write  out  1  one-cycle bus write strobe
bus_address  out  32  bus address
bus_write_data  out  32  bus write data
bus_read_data  in  32  bus read data, valid when bus_ack is high
bus_ack  in  1  bus access complete
busy  out  1  high whenever the state is not IDLE or a frame is partially received

Behaviour:
- Reset (resetn low at a clock edge):
  - state becomes IDLE; all outputs become 0.
  - byte counter, timeout counter, command register, address register, data register and TX byte count are cleared.
  - A partially received frame is discarded.
  - A pending bus_ack or UART response arriving after reset is ignored.
- Frame format, most significant byte first:
  - Read frame: CMD_READ, then 4 address bytes.
  - Write frame: CMD_WRITE, then 4 address bytes, then 4 data bytes.
- States: IDLE, RD_WAIT, RD_DONE, BUS_REQ, BUS_WAIT, TX_REQ, TX_WAIT, TX_DONE.
- IDLE:
  - If uart_rx_empty is 0, pulse uart_read for one cycle and go to RD_WAIT.
- RD_WAIT:
  - Wait for uart_read_response = 1, then capture uart_read_data[7:0] and go to RD_DONE.
- RD_DONE:
  - Wait for uart_read_response = 0. This guarantees each byte is consumed exactly once even when the response lasts multiple cycles.
  - Then dispatch the captured byte on byte_cnt:
    - byte_cnt 0: if the byte is CMD_READ or CMD_WRITE, latch it and set byte_cnt = 1. Any other byte is dropped and byte_cnt stays 0. Return to IDLE in both cases.
    - byte_cnt 1..4: shift the byte into the address register, i.e. address = {address[23:0], byte}.
    - byte_cnt 5..8 (write frames only): shift the byte into the data register the same way.
    - Frame complete (byte_cnt reaches 5 for a read, 9 for a write): clear byte_cnt and go to BUS_REQ. Otherwise increment byte_cnt and go to IDLE.
- BUS_REQ:
  - Drive bus_address and bus_write_data from the registers; they stay stable until the next BUS_REQ.
  - Pulse bus_read or bus_write for exactly one cycle.
  - Clear the timeout counter and go to BUS_WAIT.
- BUS_WAIT:
  - bus_ack is sampled only in this state.
  - On bus_ack = 1:
    - Read: latch bus_read_data and queue 4 TX bytes, MSB first.
    - Write: queue 1 TX byte, ACK_BYTE.
  - Otherwise, increment the timeout counter. When it reaches TIMEOUT_CYCLES, queue 1 TX byte, NAK_BYTE.
  - If ack and timeout occur in the same cycle, ack wins.
  - Exit to TX_REQ once a byte is queued.
- TX_REQ:
  - Drive uart_write_data = {next_byte, 24'h0} and pulse uart_write for one cycle.
  - uart_write_data is held until the next TX_REQ.
  - Go to TX_WAIT.
- TX_WAIT:
  - Wait for uart_write_response = 1, then go to TX_DONE.
- TX_DONE:
  - Wait for uart_write_response = 0.
  - If bytes remain, go to TX_REQ; otherwise go to IDLE.
- Throughput and ordering:
  - No new UART read is issued while a bus access or TX is in progress.
  - uart_read and uart_write are never high in the same cycle.
  - Minimum per received byte: 3 cycles plus the UART response latency.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). It must not wrap.

Test Plan:
- Write frame: feed 57 00 00 10 00 DE AD BE EF, respond to bus_write with bus_ack 2 cycles later -> exactly one bus_write pulse with bus_address=0x00001000 and bus_write_data=0xDEADBEEF, then one uart_write with uart_write_data=0x06000000, then busy=0.
- Read frame: feed 52 00 00 00 04, return bus_read_data=0x12345678 with bus_ack -> exactly one bus_read pulse at address 0x00000004, then four uart_write pulses with data 0x12000000, 0x34000000, 0x56000000, 0x78000000 in that order.
- Invalid command: feed 41, then a valid read frame at address 0x00000008 -> 0x41 consumed with no bus or uart_write activity; the read frame executes normally.
- Timeout: with TIMEOUT_CYCLES=16, send a read frame and never assert bus_ack -> after 16 BUS_WAIT cycles, a single uart_write of 0x15000000; no data bytes; return to IDLE. A late bus_ack in IDLE is ignored.
- Reset mid-frame: after 3 bytes of a write frame, hold resetn low for 1 cycle -> all outputs 0 and busy=0; a subsequent full write frame with 0xCAFEF00D at 0x20 executes with the correct address and data.
- Stretched responses: UART model holds read and write responses high for 2 cycles, and bus_ack arrives in the same cycle as the timeout limit -> each byte is read and sent exactly once; ACK_BYTE (not NAK) is returned.
